ps2_key_event_decoder: RTL

- Parametrised successor to the single-key PS/2 scan-code analyser.
- Consumes the PS/2 set-2 byte stream from the PS/2 receiver and decodes E0 extended, F0 break and E1 pause sequences.
- Tracks up to MAX_HELD simultaneously held keys, filters typematic repeats and maintains shift/caps state.
- Pushes press/release events into an output FIFO with ready/valid handshake, feeding the display/console logic.

---
 rtl/ps2_key_event_decoder.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 key event decoder: turns the received byte stream into
// press/release events with held-key tracking, shift/caps state and an event FIFO.
// Ports: clk/rstn; code_valid/code byte input; evt_* FWFT event FIFO head with
// evt_ready pop; press_count, held_num, shift_state, caps_lock, overflow status.
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_HELD   = 4,
    parameter int CNT_W      = 8,
    parameter bit REPEAT_EN  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          code_valid,
    input  logic [7:0]                    code,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic                          evt_make,
    output logic                          evt_ext,
    output logic                          evt_repeat,
    output logic [7:0]                    evt_scan,
    output logic [7:0]                    evt_ascii,
    output logic [CNT_W-1:0]              press_count,
    output logic [$clog2(MAX_HELD+1)-1:0] held_num,
    output logic                          shift_state,
    output logic                          caps_lock,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(MAX_HELD+1);
    localparam int EW = 19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    // Input byte register
    logic       byte_vld_q;
    logic [7:0] byte_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_vld_q <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            byte_vld_q <= code_valid;
            if (code_valid) begin
                byte_q <= code;
            end
        end
    end

    // Prefix decoder FSM
    state_t     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       dec_make, dec_brk, dec_pause, dec_ext;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        dec_make  = 1'b0;
        dec_brk   = 1'b0;
        dec_pause = 1'b0;
        dec_ext   = 1'b0;
        if (byte_vld_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_q == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (byte_q == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (byte_q == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end else if (!(byte_q inside {8'hAA, 8'hFA, 8'hEE,
                                                  8'hFE, 8'h00, 8'hFF})) begin
                        dec_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d = S_IDLE;
                        // E0 12 / E0 59 are fake shifts around extended keys
                        if (byte_q != 8'h12 && byte_q != 8'h59) begin
                            dec_make = 1'b1;
                            dec_ext  = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    dec_brk = 1'b1;
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    dec_brk = 1'b1;
                    dec_ext = 1'b1;
                    state_d = S_IDLE;
                end
                S_PAUSE: begin
                    // The 7 bytes after E1 are swallowed; the last one emits
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        dec_pause = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Held-key table lookup
    logic [MAX_HELD-1:0]       held_vld_q, held_vld_d;
    logic [MAX_HELD-1:0][8:0]  held_key_q, held_key_d;
    logic [MAX_HELD-1:0]       hit, ins_oh;
    logic                      free_seen, shift_c, hit_any, new_press;
    logic [HW-1:0]             num_c;
    logic [8:0]                key;

    assign key = {dec_ext, byte_q};

    always_comb begin
        hit       = '0;
        ins_oh    = '0;
        free_seen = 1'b0;
        shift_c   = 1'b0;
        num_c     = '0;
        for (int i = 0; i < MAX_HELD; i++) begin
            hit[i] = held_vld_q[i] && (held_key_q[i] == key);
            if (!held_vld_q[i] && !free_seen) begin
                ins_oh[i] = 1'b1;
                free_seen = 1'b1;
            end
            if (held_vld_q[i] && (held_key_q[i] == 9'h012 ||
                                  held_key_q[i] == 9'h059)) begin
                shift_c = 1'b1;
            end
            num_c = num_c + HW'(held_vld_q[i]);
        end
    end

    assign hit_any   = |hit;
    assign new_press = dec_make && !hit_any;

    always_comb begin
        held_vld_d = held_vld_q;
        held_key_d = held_key_q;
        if (new_press) begin
            // ins_oh is all-zero when full: key counted but not tracked
            for (int i = 0; i < MAX_HELD; i++) begin
                if (ins_oh[i]) begin
                    held_vld_d[i] = 1'b1;
                    held_key_d[i] = key;
                end
            end
        end else if (dec_brk) begin
            held_vld_d = held_vld_q & ~hit;
        end
    end

    // ASCII mapping (lowercase base, case applied afterwards)
    function automatic logic [7:0] ascii_lc(input logic [7:0] sc);
        case (sc)
            8'h1C: ascii_lc = 8'h61;
            8'h32: ascii_lc = 8'h62;
            8'h21: ascii_lc = 8'h63;
            8'h23: ascii_lc = 8'h64;
            8'h24: ascii_lc = 8'h65;
            8'h2B: ascii_lc = 8'h66;
            8'h34: ascii_lc = 8'h67;
            8'h33: ascii_lc = 8'h68;
            8'h43: ascii_lc = 8'h69;
            8'h3B: ascii_lc = 8'h6A;
            8'h42: ascii_lc = 8'h6B;
            8'h4B: ascii_lc = 8'h6C;
            8'h3A: ascii_lc = 8'h6D;
            8'h31: ascii_lc = 8'h6E;
            8'h44: ascii_lc = 8'h6F;
            8'h4D: ascii_lc = 8'h70;
            8'h15: ascii_lc = 8'h71;
            8'h2D: ascii_lc = 8'h72;
            8'h1B: ascii_lc = 8'h73;
            8'h2C: ascii_lc = 8'h74;
            8'h3C: ascii_lc = 8'h75;
            8'h2A: ascii_lc = 8'h76;
            8'h1D: ascii_lc = 8'h77;
            8'h22: ascii_lc = 8'h78;
            8'h35: ascii_lc = 8'h79;
            8'h1A: ascii_lc = 8'h7A;
            8'h45: ascii_lc = 8'h30;
            8'h16: ascii_lc = 8'h31;
            8'h1E: ascii_lc = 8'h32;
            8'h26: ascii_lc = 8'h33;
            8'h25: ascii_lc = 8'h34;
            8'h2E: ascii_lc = 8'h35;
            8'h36: ascii_lc = 8'h36;
            8'h3D: ascii_lc = 8'h37;
            8'h3E: ascii_lc = 8'h38;
            8'h46: ascii_lc = 8'h39;
            8'h29: ascii_lc = 8'h20;
            8'h5A: ascii_lc = 8'h0D;
            8'h66: ascii_lc = 8'h08;
            default: ascii_lc = 8'h00;
        endcase
    endfunction

    logic       caps_q, caps_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] press_q, press_d;
    logic [7:0] asc;
    logic       push;
    logic [EW-1:0] ev;

    always_comb begin
        asc = 8'h00;
        if (dec_make && !dec_ext) begin
            asc = ascii_lc(byte_q);
            if ((shift_c ^ caps_q) && asc >= 8'h61 && asc <= 8'h7A) begin
                asc = asc - 8'h20;
            end
        end
    end

    assign push = new_press || (dec_make && REPEAT_EN) || dec_brk || dec_pause;
    assign ev   = {dec_make || dec_pause, dec_ext, dec_make && hit_any,
                   dec_pause ? 8'hE1 : byte_q, asc};

    // Event FIFO (first-word-fall-through)
    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   fcnt_q, fcnt_d;
    logic          full, pop, do_push;

    assign full    = fcnt_q == (PW+1)'(FIFO_DEPTH);
    assign pop     = evt_valid && evt_ready;
    assign do_push = push && (!full || pop);

    always_comb begin
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        fcnt_d  = fcnt_q + (PW+1)'(do_push) - (PW+1)'(pop);
        caps_d  = caps_q ^ (new_press && key == 9'h058);
        press_d = press_q + CNT_W'(new_press || dec_pause);
        ovf_d   = ovf_q | (push && full && !pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            skip_q     <= 3'd0;
            held_vld_q <= '0;
            held_key_q <= '0;
            caps_q     <= 1'b0;
            press_q    <= '0;
            ovf_q      <= 1'b0;
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            held_vld_q <= held_vld_d;
            held_key_q <= held_key_d;
            caps_q     <= caps_d;
            press_q    <= press_d;
            ovf_q      <= ovf_d;
            if (do_push) begin
                mem_q[wr_q] <= ev;
            end
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign evt_valid = fcnt_q != '0;
    assign {evt_make, evt_ext, evt_repeat, evt_scan, evt_ascii} =
        evt_valid ? mem_q[rd_q] : '0;
    assign press_count = press_q;
    assign held_num    = num_c;
    assign shift_state = shift_c;
    assign caps_lock   = caps_q;
    assign overflow    = ovf_q;

endmodule
